// File: rtl/beam_result_writer.sv
// Captures one frame of beamformer output into block RAM and exposes a latency-1 read port.
// Optional peak-magnitude tracking is enabled by defining BEAM_RESULT_WRITER_PEAK_TRACK_EN.
module beam_result_writer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 11,
  parameter int FRAME_LEN = 2048
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_value,
  input  logic              in_valid,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   sample_count,
  output logic [DATA_W-1:0] peak_value,
  output logic [ADDR_W-1:0] peak_index
);

  // state     | meaning
  // S_IDLE    | after reset, waiting for first start; in_valid ignored
  // S_CAPTURE | writing one sample per in_valid cycle
  // S_DONE    | frame complete; in_valid ignored and flagged as overflow
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  localparam int              DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(FRAME_LEN - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic                w_restart;
  logic                w_wr_en;
  logic                w_overflow_hit;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W:0]     r_count;
  logic                r_overflow;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_restart    = 1'b0;
    w_wr_en      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_CAPTURE;
          w_restart    = 1'b1;
        end
      end
      S_CAPTURE: begin
        // a sample arriving with start belongs to the abandoned frame
        if (start) begin
          w_restart = 1'b1;
        end else if (in_valid) begin
          w_wr_en = 1'b1;
          if (r_count == LAST_COUNT) w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_next_state = S_CAPTURE;
          w_restart    = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_overflow_hit = (r_state == S_DONE) && in_valid && !start;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_addr  <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_restart) begin
      r_wr_addr  <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_addr <= r_wr_addr + ADDR_W'(1);
        r_count   <= r_count + (ADDR_W+1)'(1);
      end
      if (w_overflow_hit) r_overflow <= 1'b1;
    end
  end

  // RAM has no reset so it maps to block RAM; reset still blocks a pending write
  always_ff @(posedge clk) begin
    if (w_wr_en && reset_n) r_mem[r_wr_addr] <= in_value;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= r_mem[rd_addr];
    end
  end

`ifdef BEAM_RESULT_WRITER_PEAK_TRACK_EN
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAG_MAX  = {1'b0, {(DATA_W-1){1'b1}}};

  logic [DATA_W-1:0] w_mag;
  logic [DATA_W-1:0] r_peak_value;
  logic [ADDR_W-1:0] r_peak_index;

  always_comb begin
    w_mag = in_value;
    if (in_value == MOST_NEG)    w_mag = MAG_MAX;
    else if (in_value[DATA_W-1]) w_mag = ~in_value + DATA_W'(1);
  end

  // strict greater-than keeps the earliest index on ties
  always_ff @(posedge clk) begin
    if (!reset_n || w_restart) begin
      r_peak_value <= '0;
      r_peak_index <= '0;
    end else if (w_wr_en && (w_mag > r_peak_value)) begin
      r_peak_value <= w_mag;
      r_peak_index <= r_wr_addr;
    end
  end

  assign peak_value = r_peak_value;
  assign peak_index = r_peak_index;
`else
  assign peak_value = '0;
  assign peak_index = '0;
`endif

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign busy         = (r_state == S_CAPTURE);
  assign done         = (r_state == S_DONE);
  assign overflow     = r_overflow;
  assign sample_count = r_count;

endmodule

// File: tb/tb_beam_result_writer.sv
// Directed bench for beam_result_writer: a full 2048-sample instance plus an 8-deep instance
// for the gapped / full-depth frame case.
module tb_beam_result_writer;

`ifdef BEAM_RESULT_WRITER_PEAK_TRACK_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, in_valid = 1'b0, rd_en = 1'b0;
  logic [31:0] in_value = '0;
  logic [10:0] rd_addr = '0;
  logic [31:0] rd_data, peak_value;
  logic        rd_valid, busy, done, overflow;
  logic [11:0] sample_count;
  logic [10:0] peak_index;

  logic        s_start = 1'b0, s_valid = 1'b0, s_rd_en = 1'b0;
  logic [31:0] s_value = '0;
  logic [2:0]  s_rd_addr = '0;
  logic [31:0] s_rd_data, s_peak_value;
  logic        s_rd_valid, s_busy, s_done, s_overflow;
  logic [3:0]  s_count;
  logic [2:0]  s_peak_index;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  beam_result_writer #(.DATA_W(32), .ADDR_W(11), .FRAME_LEN(2048)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_value(in_value), .in_valid(in_valid),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .done(done), .overflow(overflow), .sample_count(sample_count), .peak_value(peak_value),
    .peak_index(peak_index));

  beam_result_writer #(.DATA_W(32), .ADDR_W(3), .FRAME_LEN(8)) u_small (
    .clk(clk), .reset_n(reset_n), .start(s_start), .in_value(s_value), .in_valid(s_valid),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
    .busy(s_busy), .done(s_done), .overflow(s_overflow), .sample_count(s_count),
    .peak_value(s_peak_value), .peak_index(s_peak_index));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic write_sample(input logic [31:0] v);
    in_value = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic read_big(input logic [10:0] a, output logic [31:0] d, output logic v);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, done, overflow, rd_valid, s_busy, s_done, s_overflow, s_rd_valid} !== 8'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {busy, done, overflow, rd_valid, s_busy, s_done, s_overflow, s_rd_valid});
    end
    checks++;
    if (sample_count !== 12'd0 || rd_data !== 32'd0 || peak_value !== 32'd0 || peak_index !== 11'd0) begin
      errors++;
      $display("FAIL reset_regs: got count=%0d rd_data=%h peak=%h idx=%0d expected all 0",
               sample_count, rd_data, peak_value, peak_index);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || sample_count !== 12'd0) begin
      errors++;
      $display("FAIL idle_hold: got busy=%b count=%0d expected 0 0", busy, sample_count);
    end
  endtask

  task automatic test_full_frame();
    logic [31:0] d;
    logic        v;
    int          bad = 0;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || sample_count !== 12'd0) begin
      errors++;
      $display("FAIL capture_entry: got busy=%b done=%b count=%0d expected 1 0 0", busy, done, sample_count);
    end
    for (int k = 0; k < 2048; k++) begin
      in_value = k;
      in_valid = 1'b1;
      tick();
      if (k < 2047) begin
        if (busy !== 1'b1 || done !== 1'b0 || sample_count !== 12'(k + 1)) bad++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL frame_progress: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || sample_count !== 12'd2048) begin
      errors++;
      $display("FAIL frame_done: got busy=%b done=%b count=%0d expected 0 1 2048", busy, done, sample_count);
    end
    checks++;
    if (peak_value !== (PEAK_ON ? 32'd2047 : 32'd0) || peak_index !== (PEAK_ON ? 11'd2047 : 11'd0)) begin
      errors++;
      $display("FAIL frame_peak: got %h idx %0d expected %h idx %0d", peak_value, peak_index,
               PEAK_ON ? 32'd2047 : 32'd0, PEAK_ON ? 2047 : 0);
    end
    foreach (u_addrs[i]) begin
      read_big(u_addrs[i], d, v);
      checks++;
      if (d !== 32'(u_addrs[i]) || v !== 1'b1) begin
        errors++;
        $display("FAIL frame_read: addr %0d got %h valid %b expected %h valid 1", u_addrs[i], d, v, 32'(u_addrs[i]));
      end
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'd2047) begin
      errors++;
      $display("FAIL read_hold: got valid=%b data=%h expected 0 000007ff", rd_valid, rd_data);
    end
  endtask

  logic [10:0] u_addrs [4] = '{11'd0, 11'd1, 11'd1000, 11'd2047};

  task automatic test_overflow();
    logic [31:0] d;
    logic        v;
    for (int i = 0; i < 3; i++) begin
      write_sample(32'hDEAD);
      tick();
    end
    checks++;
    if (overflow !== 1'b1 || done !== 1'b1 || sample_count !== 12'd2048) begin
      errors++;
      $display("FAIL overflow_set: got ovf=%b done=%b count=%0d expected 1 1 2048", overflow, done, sample_count);
    end
    for (int a = 0; a < 3; a++) begin
      read_big(11'(a), d, v);
      checks++;
      if (d !== 32'(a)) begin
        errors++;
        $display("FAIL overflow_mem: addr %0d got %h expected %h", a, d, 32'(a));
      end
    end
    pulse_start();
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || sample_count !== 12'd0) begin
      errors++;
      $display("FAIL overflow_clear: got ovf=%b busy=%b done=%b count=%0d expected 0 1 0 0",
               overflow, busy, done, sample_count);
    end
  endtask

  task automatic test_read_first();
    for (int a = 0; a < 6; a++) write_sample(a == 5 ? 32'h11 : 32'h0);
    pulse_start();
    for (int a = 0; a < 5; a++) write_sample(32'h30 + a);
    in_value = 32'h22;
    in_valid = 1'b1;
    rd_en    = 1'b1;
    rd_addr  = 11'd5;
    tick();
    in_valid = 1'b0;
    checks++;
    if (rd_data !== 32'h11 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_first_old: got %h valid %b expected 00000011 valid 1", rd_data, rd_valid);
    end
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_data !== 32'h22 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_first_new: got %h valid %b expected 00000022 valid 1", rd_data, rd_valid);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h22) begin
      errors++;
      $display("FAIL read_valid_drop: got valid %b data %h expected 0 00000022", rd_valid, rd_data);
    end
  endtask

  task automatic test_peak();
    logic [31:0] vals [4] = '{32'd3, 32'hFFFF_FFF7, 32'd9, 32'h8000_0000};
    pulse_start();
    for (int i = 0; i < 3; i++) write_sample(vals[i]);
    checks++;
    if (peak_value !== (PEAK_ON ? 32'd9 : 32'd0) || peak_index !== (PEAK_ON ? 11'd1 : 11'd0)) begin
      errors++;
      $display("FAIL peak_tie: got %h idx %0d expected %h idx %0d", peak_value, peak_index,
               PEAK_ON ? 32'd9 : 32'd0, PEAK_ON ? 1 : 0);
    end
    write_sample(vals[3]);
    checks++;
    if (peak_value !== (PEAK_ON ? 32'h7FFF_FFFF : 32'd0) || peak_index !== (PEAK_ON ? 11'd3 : 11'd0)) begin
      errors++;
      $display("FAIL peak_most_neg: got %h idx %0d expected %h idx %0d", peak_value, peak_index,
               PEAK_ON ? 32'h7FFF_FFFF : 32'd0, PEAK_ON ? 3 : 0);
    end
  endtask

  task automatic test_gapped();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      s_valid = (i % 3 == 0);
      s_value = 32'h50 + i / 3;
      tick();
      if (i == 18) begin
        checks++;
        if (s_done !== 1'b0 || s_busy !== 1'b1 || s_count !== 4'd7) begin
          errors++;
          $display("FAIL gap_seventh: got done=%b busy=%b count=%0d expected 0 1 7", s_done, s_busy, s_count);
        end
      end
    end
    s_valid = 1'b0;
    checks++;
    if (s_done !== 1'b1 || s_busy !== 1'b0 || s_count !== 4'd8 || s_overflow !== 1'b0) begin
      errors++;
      $display("FAIL gap_done: got done=%b busy=%b count=%0d ovf=%b expected 1 0 8 0",
               s_done, s_busy, s_count, s_overflow);
    end
    for (int a = 0; a < 8; a++) begin
      s_rd_en   = 1'b1;
      s_rd_addr = 3'(a);
      tick();
      s_rd_en = 1'b0;
      checks++;
      if (s_rd_data !== 32'h50 + a || s_rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL gap_mem: addr %0d got %h valid %b expected %h valid 1", a, s_rd_data, s_rd_valid, 32'h50 + a);
      end
    end
    checks++;
    if (s_peak_value !== (PEAK_ON ? 32'h57 : 32'd0) || s_peak_index !== (PEAK_ON ? 3'd7 : 3'd0)) begin
      errors++;
      $display("FAIL gap_peak: got %h idx %0d expected %h idx %0d", s_peak_value, s_peak_index,
               PEAK_ON ? 32'h57 : 32'd0, PEAK_ON ? 7 : 0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        v;
    pulse_start();
    for (int k = 0; k < 100; k++) write_sample(32'h100 + k);
    reset_n = 1'b0;
    tick();
    checks++;
    if ({busy, done, overflow, rd_valid} !== 4'b0 || sample_count !== 12'd0 || rd_data !== 32'd0 ||
        peak_value !== 32'd0 || peak_index !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset: got flags=%b count=%0d rd_data=%h peak=%h idx=%0d expected all 0",
               {busy, done, overflow, rd_valid}, sample_count, rd_data, peak_value, peak_index);
    end
    reset_n  = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_value = 32'hBAD;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || sample_count !== 12'd0) begin
      errors++;
      $display("FAIL start_drop: got busy=%b count=%0d expected 1 0", busy, sample_count);
    end
    write_sample(32'hABC);
    checks++;
    if (sample_count !== 12'd1) begin
      errors++;
      $display("FAIL recapture_count: got %0d expected 1", sample_count);
    end
    read_big(11'd0, d, v);
    checks++;
    if (d !== 32'hABC) begin
      errors++;
      $display("FAIL recapture_addr0: got %h expected 00000abc", d);
    end
    read_big(11'd1, d, v);
    checks++;
    if (d !== 32'h101) begin
      errors++;
      $display("FAIL partial_kept: got %h expected 00000101", d);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_overflow();
    test_read_first();
    test_peak();
    test_gapped();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
